// File: rtl/tree_sched_pkg.sv
// Shared types, default sizes and helpers for the tree-ensemble scheduler.
package tree_sched_pkg;

    localparam int unsigned N_TREES_DEF = 8;
    localparam int unsigned TIMEOUT_DEF = 1024;
    localparam int unsigned IDX_W       = $clog2(N_TREES_DEF);
    localparam int unsigned TMO_W       = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Sign-extend the low w bits of v (bits above w are expected to be zero).
    function automatic logic [63:0] sext64(input logic [63:0] v, input int unsigned w);
        logic [63:0] hi_mask;
        hi_mask = ~64'd0 << w;
        return v[6'(w - 1)] ? (v | hi_mask) : (v & ~hi_mask);
    endfunction

endpackage

// File: rtl/tree_sched_accum.sv
// Serial accumulator for the SUM phase: one per-tree score added per cycle onto BIAS.
module tree_sched_accum
    import tree_sched_pkg::*;
#(
    parameter int unsigned             N_TREES = N_TREES_DEF,
    parameter int unsigned             SCORE_W = 18,
    parameter int unsigned             ACC_W   = 22,
    parameter logic signed [ACC_W-1:0] BIAS    = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic                            en,
    input  logic [N_TREES*SCORE_W-1:0]      scores,
    output logic signed [ACC_W-1:0]         acc,
    output logic                            last_c
);

    localparam int unsigned IW = (N_TREES > 1) ? $clog2(N_TREES) : 1;

    logic [IW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SCORE_W-1:0]      score_sel;

    always_comb begin
        idx_d     = idx_q;
        acc_d     = acc_q;
        score_sel = scores[idx_q * SCORE_W +: SCORE_W];
        if (load) begin
            idx_d = '0;
            acc_d = BIAS;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(sext64(64'(score_sel), SCORE_W));
            idx_d = (idx_q == IW'(N_TREES - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

    assign acc    = acc_q;
    assign last_c = en && (idx_q == IW'(N_TREES - 1));

endmodule

// File: rtl/tree_ensemble_sched.sv
// Starts N_TREES ap_ctrl_hs engines, collects their scores, sums them onto BIAS.
// Optional RUN watchdog enabled by defining TREE_SCHED_TIMEOUT_EN.
module tree_ensemble_sched
    import tree_sched_pkg::*;
#(
    parameter int unsigned             N_TREES        = N_TREES_DEF,
    parameter int unsigned             SCORE_W        = 18,
    parameter int unsigned             ACC_W          = 22,
    parameter logic signed [ACC_W-1:0] BIAS           = '0,
    parameter int unsigned             TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N_TREES-1:0]           eng_start,
    input  logic [N_TREES-1:0]           eng_ready,
    input  logic [N_TREES-1:0]           eng_done,
    input  logic [N_TREES*SCORE_W-1:0]   eng_score,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_W-1:0]      out_score,
    output logic                         out_err,
    output logic                         busy
);

    if (ACC_W < SCORE_W + $clog2(N_TREES + 1) || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("tree_ensemble_sched: ACC_W too narrow for the ensemble sum or TIMEOUT_CYCLES is zero");
    end

    state_e                     state_q, state_d;
    logic [N_TREES-1:0]         start_pend_q, start_pend_d;
    logic [N_TREES-1:0]         done_seen_q, done_seen_d;
    logic [N_TREES*SCORE_W-1:0] score_q, score_d;
    logic                       in_ready_q, in_ready_d;
    logic                       busy_q, busy_d;
    logic                       out_valid_q, out_valid_d;
    logic                       acc_load, acc_en, acc_last_c;

`ifdef TREE_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        done_seen_d  = done_seen_q;
        score_d      = score_q;
        acc_load     = 1'b0;
        acc_en       = 1'b0;
`ifdef TREE_SCHED_TIMEOUT_EN
        err_d        = err_q;
        tmo_d        = (state_q == RUN) ? tmo_q + TW'(1) : '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    start_pend_d = '1;
                    done_seen_d  = '0;
                    score_d      = '0;
                    state_d      = RUN;
`ifdef TREE_SCHED_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end
            end
            RUN: begin
                start_pend_d = start_pend_q & ~eng_ready;
                // Only the first done per engine captures its score.
                for (int unsigned k = 0; k < N_TREES; k++) begin
                    if (eng_done[k] && !done_seen_q[k]) begin
                        done_seen_d[k]                    = 1'b1;
                        score_d[k*SCORE_W +: SCORE_W] = eng_score[k*SCORE_W +: SCORE_W];
                    end
                end
                if (&done_seen_d) begin
                    state_d      = SUM;
                    start_pend_d = '0;
                    acc_load     = 1'b1;
                end
`ifdef TREE_SCHED_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = SUM;
                    start_pend_d = '0;
                    acc_load     = 1'b1;
                    err_d        = 1'b1;
                end
`endif
            end
            SUM: begin
                acc_en = 1'b1;
                if (acc_last_c) state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef TREE_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            start_pend_q <= '0;
            done_seen_q  <= '0;
            score_q      <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            done_seen_q  <= done_seen_d;
            score_q      <= score_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
        end
    end

`ifdef TREE_SCHED_TIMEOUT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    tree_sched_accum #(
        .N_TREES (N_TREES),
        .SCORE_W (SCORE_W),
        .ACC_W   (ACC_W),
        .BIAS    (BIAS)
    ) u_accum (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .load   (acc_load),
        .en     (acc_en),
        .scores (score_q),
        .acc    (out_score),
        .last_c (acc_last_c)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign eng_start = start_pend_q;

endmodule
